// File: rtl/vec_mem_wb_stage.sv
// vec_mem_wb_stage: MEM->WB pipeline register for the vector datapath.
// Valid/ready handshake with a two-entry (main + skid) buffer, synchronous
// flush and per-lane write enables. in_ready is fully registered.
// Optional macro VEC_MEM_WB_PERF_CNT_EN adds saturating stall/bubble counters.
module vec_mem_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     RegWrite_i,
  input  logic                     MemtoReg_i,
  input  logic [LANES-1:0]         lane_mask_i,
  input  logic [LANES*DATA_W-1:0]  alu_result_i,
  input  logic [LANES*DATA_W-1:0]  read_data_i,
  input  logic [ADDR_W-1:0]        write_addr_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     RegWrite_o,
  output logic                     MemtoReg_o,
  output logic [LANES-1:0]         lane_we_o,
  output logic [LANES*DATA_W-1:0]  alu_result_o,
  output logic [LANES*DATA_W-1:0]  read_data_o,
`ifdef VEC_MEM_WB_PERF_CNT_EN
  output logic [31:0]              stall_cnt_o,
  output logic [31:0]              bubble_cnt_o,
`endif
  output logic [ADDR_W-1:0]        write_addr_o
);

  localparam int unsigned VEC_W = LANES * DATA_W;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [LANES-1:0]  mask;
    logic [VEC_W-1:0]  alu;
    logic [VEC_W-1:0]  rdata;
    logic [ADDR_W-1:0] addr;
  } beat_t;

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  beat_t in_beat;
  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  in_ready_q, in_ready_d;
  logic  in_fire, out_fire;

  assign in_beat = '{regwrite: RegWrite_i,
                     memtoreg: MemtoReg_i,
                     mask:     lane_mask_i,
                     alu:      alu_result_i,
                     rdata:    read_data_i,
                     addr:     write_addr_i};

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid_q & out_ready;

  // Next-state for the main/skid buffer; flush overrides every load and transfer
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low while the skid holds a beat, so no input can fire here
      if (out_fire) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || out_fire) begin
      main_valid_d = in_fire;
      if (in_fire) begin
        main_d = in_beat;
      end
    end else if (in_fire) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
    // Registered ready: tracks the skid occupancy one edge later
    in_ready_d = ~skid_valid_d;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_valid_q;
  assign RegWrite_o   = main_q.regwrite & main_valid_q;
  assign MemtoReg_o   = main_q.memtoreg;
  assign lane_we_o    = main_q.mask & {LANES{RegWrite_o}};
  assign alu_result_o = main_q.alu;
  assign read_data_o  = main_q.rdata;
  assign write_addr_o = main_q.addr;

`ifdef VEC_MEM_WB_PERF_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Saturating stall/bubble counters; only rst_n clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (main_valid_q && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (!main_valid_q && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_vec_mem_wb_stage.sv
// Testbench for vec_mem_wb_stage: depth-2 queue model checked every cycle,
// plus directed literal expectations.
module tb_vec_mem_wb_stage;

  localparam int DW = 32;
  localparam int L  = 4;
  localparam int AW = 5;
  localparam int VW = DW * L;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          RegWrite_i, MemtoReg_i;
  logic [L-1:0]  lane_mask_i;
  logic [VW-1:0] alu_result_i, read_data_i;
  logic [AW-1:0] write_addr_i;
  logic          out_valid;
  logic          out_ready;
  logic          RegWrite_o, MemtoReg_o;
  logic [L-1:0]  lane_we_o;
  logic [VW-1:0] alu_result_o, read_data_o;
  logic [AW-1:0] write_addr_o;
`ifdef VEC_MEM_WB_PERF_CNT_EN
  logic [31:0]   stall_cnt_o, bubble_cnt_o;
`endif

  vec_mem_wb_stage #(.DATA_W(DW), .LANES(L), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .lane_mask_i(lane_mask_i),
    .alu_result_i(alu_result_i), .read_data_i(read_data_i), .write_addr_i(write_addr_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .lane_we_o(lane_we_o),
    .alu_result_o(alu_result_o), .read_data_o(read_data_o),
`ifdef VEC_MEM_WB_PERF_CNT_EN
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o),
`endif
    .write_addr_o(write_addr_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a 2-deep FIFO ----------------
  typedef struct {
    logic          rw;
    logic          m2r;
    logic [L-1:0]  mask;
    logic [VW-1:0] alu;
    logic [VW-1:0] rd;
    logic [AW-1:0] addr;
  } mbeat_t;

  mbeat_t      q[$];
  bit          m_ir;
  bit          ir_known;
  logic [31:0] stall_m, bubble_m;
  bit          seen_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ir     = 1'b0;
      ir_known = 1'b0;
      stall_m  = '0;
      bubble_m = '0;
    end else begin
      mbeat_t b;
      bit in_f, out_f;
      if (q.size() > 0 && !out_ready && stall_m != 32'hFFFF_FFFF) stall_m++;
      if (q.size() == 0 && bubble_m != 32'hFFFF_FFFF) bubble_m++;
      in_f  = in_valid && m_ir;
      out_f = (q.size() > 0) && out_ready;
      b = '{rw: RegWrite_i, m2r: MemtoReg_i, mask: lane_mask_i,
            alu: alu_result_i, rd: read_data_i, addr: write_addr_i};
      if (flush) q.delete();
      else begin
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(b);
      end
      m_ir     = (q.size() < 2);
      ir_known = 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      bit v;
      v = (q.size() > 0);
      chk("out_valid", out_valid, v);
      if (ir_known) chk("in_ready", in_ready, m_ir);
      chk("RegWrite_o", RegWrite_o, v ? q[0].rw : 1'b0);
      chk("lane_we_o", lane_we_o, (v && q[0].rw) ? q[0].mask : '0);
      if (v) begin
        chk("MemtoReg_o", MemtoReg_o, q[0].m2r);
        chk("alu_result_o", alu_result_o, q[0].alu);
        chk("read_data_o", read_data_o, q[0].rd);
        chk("write_addr_o", write_addr_o, q[0].addr);
      end
`ifdef VEC_MEM_WB_PERF_CNT_EN
      chk("stall_cnt_o", stall_cnt_o, stall_m);
      chk("bubble_cnt_o", bubble_cnt_o, bubble_m);
`endif
      if (out_valid && write_addr_o == 5'd13) seen_c = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [VW-1:0] mk_alu(input logic [31:0] base);
    logic [VW-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = base + (32'(i) << 8);
    return r;
  endfunction

  function automatic logic [VW-1:0] mk_rd(input logic [AW-1:0] addr);
    logic [VW-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = 32'hAAAA_0000 + 32'(i) + (32'(addr) << 8);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r, input logic [L-1:0] mask,
                       input logic [31:0] base, input logic [AW-1:0] addr);
    in_valid     = v;
    RegWrite_i   = rw;
    MemtoReg_i   = m2r;
    lane_mask_i  = mask;
    alu_result_i = mk_alu(base);
    read_data_i  = mk_rd(addr);
    write_addr_i = addr;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_RegWrite_o"}, RegWrite_o, 1'b0);
    chk({tag, "_MemtoReg_o"}, MemtoReg_o, 1'b0);
    chk({tag, "_lane_we_o"}, lane_we_o, 4'h0);
    chk({tag, "_alu_result_o"}, alu_result_o, 128'h0);
    chk({tag, "_read_data_o"}, read_data_o, 128'h0);
    chk({tag, "_write_addr_o"}, write_addr_o, 5'd0);
  endtask

  logic [VW-1:0] exp_rd;
`ifdef VEC_MEM_WB_PERF_CNT_EN
  logic [31:0] stall_snap;
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; seen_c = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, 32'h0, '0);

    // Reset then idle
    #23;
    chk_reset_outputs("reset");
`ifdef VEC_MEM_WB_PERF_CNT_EN
    chk("reset_stall_cnt", stall_cnt_o, 32'd0);
    chk("reset_bubble_cnt", bubble_cnt_o, 32'd0);
`endif
    @(negedge clk); #2 rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_out_valid", out_valid, 1'b0);
    repeat (3) step();
`ifdef VEC_MEM_WB_PERF_CNT_EN
    @(negedge clk);
    chk("idle_bubble_cnt", bubble_cnt_o, 32'd4);
`endif

    // Streaming: 8 back-to-back beats
    for (int k = 0; k < 8; k++) begin
      step();
      drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h10 + 32'(k), AW'(k + 1));
      if (k > 0) begin
        @(negedge clk);
        chk("stream_addr", write_addr_o, 5'(k));
        chk("stream_lane0", alu_result_o[31:0], 32'h10 + 32'(k - 1));
        chk("stream_we", lane_we_o, 4'hF);
      end
    end
    step(); idle();
    @(negedge clk);
    chk("stream_last_addr", write_addr_o, 5'd8);
    chk("stream_last_lane0", alu_result_o[31:0], 32'h17);

    // Beat with RegWrite=0: no lane enables
    step(); drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h50, 5'd9);
    step(); idle();
    @(negedge clk);
    chk("norw_valid", out_valid, 1'b1);
    chk("norw_RegWrite_o", RegWrite_o, 1'b0);
    chk("norw_lane_we", lane_we_o, 4'h0);
`ifdef VEC_MEM_WB_PERF_CNT_EN
    stall_snap = stall_cnt_o;
`endif

    // Backpressure: A held, B in skid
    step(); out_ready = 1'b0; drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 5'd20);
    step(); drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h21, 5'd21);
    step(); idle();
    @(negedge clk);
    chk("bp_hold_valid", out_valid, 1'b1);
    chk("bp_hold_addr", write_addr_o, 5'd20);
    chk("bp_in_ready_low", in_ready, 1'b0);
    step(); step();
    @(negedge clk);
    chk("bp_still_addr", write_addr_o, 5'd20);
    step(); out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_b_addr", write_addr_o, 5'd21);
    chk("bp_in_ready_high", in_ready, 1'b1);
    step();
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);
`ifdef VEC_MEM_WB_PERF_CNT_EN
    chk("bp_stall_delta", stall_cnt_o - stall_snap, 32'd4);
`endif

    // Flush with skid full and C offered
    step(); out_ready = 1'b0; drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h30, 5'd10);
    step(); drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h31, 5'd11);
    step(); flush = 1'b1; drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h33, 5'd13);
    step(); flush = 1'b0; idle();
    @(negedge clk);
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_RegWrite_o", RegWrite_o, 1'b0);
    chk("fl_lane_we", lane_we_o, 4'h0);
    chk("fl_in_ready", in_ready, 1'b1);
    step(); out_ready = 1'b1;
    repeat (4) step();

    // Masking / MemtoReg
    step(); drive(1'b1, 1'b1, 1'b1, 4'b0101, 32'h40, 5'd0);
    step(); drive(1'b1, 1'b1, 1'b1, 4'b0000, 32'h41, 5'd0);
    @(negedge clk);
    exp_rd = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    chk("mask_lane_we", lane_we_o, 4'b0101);
    chk("mask_MemtoReg_o", MemtoReg_o, 1'b1);
    chk("mask_read_data", read_data_o, exp_rd);
    step(); idle();
    @(negedge clk);
    chk("mask0_RegWrite_o", RegWrite_o, 1'b1);
    chk("mask0_lane_we", lane_we_o, 4'h0);

    // Async reset mid-stall
    step(); out_ready = 1'b0; drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h60, 5'd14);
    step(); drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h61, 5'd15);
    step(); idle();
    @(negedge clk);
    chk("ar_pre_addr", write_addr_o, 5'd14);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
`ifdef VEC_MEM_WB_PERF_CNT_EN
    chk("async_rst_stall_cnt", stall_cnt_o, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("ar_no_beat", out_valid, 1'b0);

    chk("flush_drop_c", seen_c, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vec_mem_wb_stage.md
Name: vec_mem_wb_stage

Overview:
Parametrised MEM->WB pipeline register for the vector datapath. It carries write-back control, ALU results, load data and destination address for LANES lanes. It replaces the plain always-load register with a valid/ready handshake, a 2-entry skid buffer (main + skid), a synchronous flush and per-lane write enables. It sits between the vector memory stage and the vector register-file write port.

Parameters:
DATA_W, 32, bits per lane element
LANES, 4, number of vector lanes
ADDR_W, 5, destination register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; kills all held entries
in_valid  in  1  MEM stage offers a beat
in_ready  out  1  stage can accept a beat; registered, equals !skid_valid
RegWrite_i  in  1  beat writes the register file
MemtoReg_i  in  1  1 = write-back selects read_data, 0 = alu_result
lane_mask_i  in  LANES  active lanes of the beat
alu_result_i  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
read_data_i  in  LANES*DATA_W  load data, same packing
write_addr_i  in  ADDR_W  destination vector register
out_valid  out  1  WB beat present
out_ready  in  1  WB consumes the beat
RegWrite_o  out  1  RegWrite of held beat AND out_valid
MemtoReg_o  out  1  held MemtoReg
lane_we_o  out  LANES  per-lane write enable = lane_mask & {LANES{RegWrite_o}}
alu_result_o  out  LANES*DATA_W  held ALU result
read_data_o  out  LANES*DATA_W  held load data
write_addr_o  out  ADDR_W  held destination

Behaviour:
- Reset (rst_n low, async): main_valid = 0, skid_valid = 0, and all data/control outputs = 0. After release, in_ready = 1 and out_valid = 0.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. out_valid = main_valid.
- Data and control in main are stable while out_valid & !out_ready. No output changes until out_fire.
- Latency: 1 cycle, in_fire at edge N gives out_valid after edge N. Throughput is 1 beat/cycle while out_ready stays high.
- Update rules per edge, no flush:
  - main empty, or out_fire with skid empty: in_fire loads main; otherwise main_valid <= 0 on out_fire.
  - main full, !out_ready, in_fire: beat goes to skid, skid_valid <= 1.
  - out_fire with skid full: main <= skid, skid_valid <= 0. in_ready is 0 in that cycle, so no input is taken.
- in_ready is purely registered (no combinational path from out_ready). It drops the cycle after the skid fills and rises the cycle after the skid drains.
- Flush: main_valid, skid_valid <= 0 and in_ready <= 1.
  - A beat offered in the same cycle as flush is dropped.
  - flush has priority over every load and transfer.
  - Data registers may keep stale values, but RegWrite_o and lane_we_o are 0 because out_valid is 0.
- lane_mask_i = 0 with RegWrite_i = 1 is legal: RegWrite_o = 1, lane_we_o = 0.
- No arithmetic. Widths are passed through unchanged.
- Reset mid-stall: all beats are lost, and outputs return to reset values immediately.

Optional Feature:
Macro VEC_MEM_WB_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and bubble_cnt_o[31:0].
  - stall_cnt_o counts cycles with out_valid & !out_ready.
  - bubble_cnt_o counts cycles with !out_valid.
  - Both saturate at 32'hFFFF_FFFF, are cleared only by rst_n, and are not cleared by flush.
- Undefined: the ports and the counter logic do not exist, and all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_n=0 → all outputs 0. Release → in_ready=1 and out_valid=0 next cycle. With the macro defined, bubble_cnt_o increments 1 per idle cycle.
- Streaming: LANES=4, out_ready=1. Send 8 beats back to back with alu_result lane0 = 0x10..0x17, write_addr 1..8, RegWrite=1, mask=4'hF → each appears 1 cycle later, in order; lane_we_o=4'hF every cycle.
- Backpressure: out_ready=0 and send beats A,B → A held on outputs, B in skid, in_ready=0 on the cycle after B. Raise out_ready → A then B in consecutive cycles; in_ready=1 the cycle after B moves to main; stall_cnt_o equals the number of stalled cycles.
- Flush: skid full (A,B held), assert flush with C offered → next cycle out_valid=0, RegWrite_o=0, lane_we_o=0, in_ready=1; C never appears.
- Masking/MemtoReg: beat with RegWrite=1, MemtoReg=1, mask=4'b0101, read_data lanes 0xAAAA_0000..0xAAAA_0003 → lane_we_o=4'b0101, MemtoReg_o=1, read_data_o matches. Repeat with mask=0 → RegWrite_o=1, lane_we_o=0.
- Async reset mid-stall: with A,B held, pulse rst_n low between edges → outputs 0 immediately without a clock edge; no beat emitted after release.
